// File: rtl/writeback_buffer_pkg.sv
// rtl/writeback_buffer_pkg.sv - shared types and helpers for the line write-back buffer
//
// Purpose: address/data widths, FSM state encodings and per-entry metadata
//          used by writeback_buffer and wb_line_store.
// Contents: ADDR_WIDTH, DATA_WIDTH, wb_cap_state_t, wb_drain_state_t,
//           wb_read_state_t, wb_entry_meta_t, same_line().
package writeback_buffer_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        CAP_IDLE,
        CAP_FILL
    } wb_cap_state_t;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_GO,
        DR_STREAM
    } wb_drain_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_HOLD
    } wb_read_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] base;
        logic                  valid;
    } wb_entry_meta_t;

    // Line-granular address match: byte and word offset bits are ignored so a
    // refill with any address inside a buffered line is treated as a hazard.
    function automatic logic same_line(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [ADDR_WIDTH-1:0] b,
                                       input int unsigned            offset_bits);
        logic [ADDR_WIDTH-1:0] mask;
        mask = {ADDR_WIDTH{1'b1}} << offset_bits;
        return (a & mask) == (b & mask);
    endfunction

endpackage

// File: rtl/wb_line_store.sv
// rtl/wb_line_store.sv - DEPTH x LINE_WORDS data word array for buffered lines
//
// Purpose: holds the data words of every buffered line.
// Ports:
//   clk                         clock
//   wr_entry/wr_word/wr_data/wr_en   single synchronous write port
//   rd_entry/rd_word -> rd_data      asynchronous read port
module wb_line_store
    import writeback_buffer_pkg::*;
#(
    parameter  int DEPTH              = 2,
    parameter  int BLOCK_OFFSET_WIDTH = 2,
    localparam int PTR_W              = $clog2(DEPTH),
    localparam int LINE_WORDS         = 1 << BLOCK_OFFSET_WIDTH
) (
    input  logic                          clk,
    input  logic [PTR_W-1:0]              wr_entry,
    input  logic [BLOCK_OFFSET_WIDTH-1:0] wr_word,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_en,
    input  logic [PTR_W-1:0]              rd_entry,
    input  logic [BLOCK_OFFSET_WIDTH-1:0] rd_word,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    // Plain storage, no reset: contents are only meaningful behind a valid bit.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH*LINE_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_entry, wr_word}] <= wr_data;
        end
    end

    assign rd_data = mem_q[{rd_entry, rd_word}];

endmodule

// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - line write-back buffer between d_cache memory ports and memory
//
// Purpose: captures flushed dirty lines into a circular FIFO, drains them to
//          memory in the background, and holds refills that hit a buffered line.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   up_write_*                  flush port facing the d_cache write requester
//   dn_write_*                  write request toward memory
//   up_read_*                   refill port facing the d_cache read requester
//   dn_read_*                   read request toward memory
//   occupancy                   valid plus capturing entries
// Configuration:
//   WRITEBACK_BUFFER_HAZARD_CHECK_EN  defined: per-entry line address compare;
//                                     undefined: any buffered line holds every read.
module writeback_buffer
    import writeback_buffer_pkg::*;
#(
    parameter  int DEPTH              = 2,
    parameter  int BLOCK_OFFSET_WIDTH = 2,
    localparam int PTR_W              = $clog2(DEPTH),
    localparam int OCC_W              = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  up_write_control_go,
    input  logic [ADDR_WIDTH-1:0] up_write_control_base,
    input  logic [ADDR_WIDTH-1:0] up_write_control_length,
    output logic                  up_write_control_done,
    input  logic [DATA_WIDTH-1:0] up_write_user_data,
    input  logic                  up_write_user_we,
    output logic                  up_write_user_full,

    output logic                  dn_write_control_go,
    output logic [ADDR_WIDTH-1:0] dn_write_control_base,
    output logic [ADDR_WIDTH-1:0] dn_write_control_length,
    input  logic                  dn_write_control_done,
    output logic [DATA_WIDTH-1:0] dn_write_user_data,
    output logic                  dn_write_user_we,
    input  logic                  dn_write_user_full,

    input  logic                  up_read_control_go,
    input  logic [ADDR_WIDTH-1:0] up_read_control_base,
    input  logic [ADDR_WIDTH-1:0] up_read_control_length,
    output logic                  up_read_control_done,
    output logic                  up_read_user_available,
    output logic [DATA_WIDTH-1:0] up_read_user_data,
    input  logic                  up_read_user_re,

    output logic                  dn_read_control_go,
    output logic [ADDR_WIDTH-1:0] dn_read_control_base,
    output logic [ADDR_WIDTH-1:0] dn_read_control_length,
    input  logic                  dn_read_control_done,
    input  logic                  dn_read_user_available,
    input  logic [DATA_WIDTH-1:0] dn_read_user_data,
    output logic                  dn_read_user_re,

    output logic [OCC_W-1:0]      occupancy
);

    localparam int                  LINE_WORDS = 1 << BLOCK_OFFSET_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(LINE_WORDS << 2);
    localparam logic [OCC_W-1:0]    DEPTH_OCC  = OCC_W'(DEPTH);

    // Every line is a fixed size, so the flush length carries no information.
    logic unused_length;
    assign unused_length = ^up_write_control_length;

    wb_cap_state_t                 cap_state_q, cap_state_d;
    logic [BLOCK_OFFSET_WIDTH-1:0] cap_word_q,  cap_word_d;
    logic [PTR_W-1:0]              tail_q,      tail_d;

    wb_drain_state_t               dr_state_q,  dr_state_d;
    logic [BLOCK_OFFSET_WIDTH-1:0] dr_word_q,   dr_word_d;
    logic [PTR_W-1:0]              head_q,      head_d;

    wb_read_state_t                rd_state_q,  rd_state_d;
    logic [ADDR_WIDTH-1:0]         rd_base_q,   rd_base_d;
    logic [ADDR_WIDTH-1:0]         rd_len_q,    rd_len_d;

    wb_entry_meta_t                meta_q [DEPTH];
    wb_entry_meta_t                meta_d [DEPTH];
    logic [OCC_W-1:0]              valid_cnt_q, valid_cnt_d;

    logic                          cap_accept;
    logic                          cap_wr;
    logic                          cap_last;
    logic                          dr_last;
    logic                          up_conflict;
    logic                          hold_conflict;
    logic                          rd_fire_held;
    wb_entry_meta_t                head_meta;

    // A line being captured already counts, so the flush port closes while
    // the last free slot is still filling.
    assign occupancy             = valid_cnt_q + OCC_W'(cap_state_q == CAP_FILL);
    assign up_write_control_done = (cap_state_q == CAP_IDLE) && (occupancy < DEPTH_OCC);
    assign up_write_user_full    = 1'b0;

    assign cap_accept = up_write_control_done && up_write_control_go;
    assign cap_wr     = (cap_state_q == CAP_FILL) && up_write_user_we;
    assign cap_last   = cap_wr && (&cap_word_q);

    assign head_meta               = meta_q[head_q];
    assign dn_write_control_go     = (dr_state_q == DR_GO);
    assign dn_write_control_base   = head_meta.base;
    assign dn_write_control_length = LINE_BYTES;
    assign dn_write_user_we        = (dr_state_q == DR_STREAM) && !dn_write_user_full;
    assign dr_last                 = dn_write_user_we && (&dr_word_q);

    wb_line_store #(
        .DEPTH              (DEPTH),
        .BLOCK_OFFSET_WIDTH (BLOCK_OFFSET_WIDTH)
    ) u_line_store (
        .clk      (clk),
        .wr_entry (tail_q),
        .wr_word  (cap_word_q),
        .wr_data  (up_write_user_data),
        .wr_en    (cap_wr),
        .rd_entry (head_q),
        .rd_word  (dr_word_q),
        .rd_data  (dn_write_user_data)
    );

`ifdef WRITEBACK_BUFFER_HAZARD_CHECK_EN
    // An entry is live from the moment its base is latched until its last
    // word has been accepted downstream.
    logic entry_live [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_live[i] = meta_q[i].valid ||
                            ((cap_state_q == CAP_FILL) && (tail_q == PTR_W'(i)));
        end
    end

    always_comb begin
        up_conflict   = 1'b0;
        hold_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live[i] && same_line(meta_q[i].base, up_read_control_base,
                                           BLOCK_OFFSET_WIDTH + 2)) begin
                up_conflict = 1'b1;
            end
            if (entry_live[i] && same_line(meta_q[i].base, rd_base_q,
                                           BLOCK_OFFSET_WIDTH + 2)) begin
                hold_conflict = 1'b1;
            end
        end
    end
`else
    // Without comparators every read waits for an empty buffer.
    always_comb begin
        up_conflict   = (occupancy != '0);
        hold_conflict = (occupancy != '0);
    end
`endif

    assign rd_fire_held = (rd_state_q == RD_HOLD) && !hold_conflict && dn_read_control_done;

    assign dn_read_control_go     = (rd_state_q == RD_IDLE) ? (up_read_control_go && !up_conflict)
                                                            : rd_fire_held;
    assign dn_read_control_base   = (rd_state_q == RD_HOLD) ? rd_base_q : up_read_control_base;
    assign dn_read_control_length = (rd_state_q == RD_HOLD) ? rd_len_q  : up_read_control_length;
    assign up_read_control_done   = dn_read_control_done && (rd_state_q == RD_IDLE);

    assign up_read_user_available = dn_read_user_available;
    assign up_read_user_data      = dn_read_user_data;
    assign dn_read_user_re        = up_read_user_re;

    // Capture FSM
    always_comb begin
        cap_state_d = cap_state_q;
        cap_word_d  = cap_word_q;
        tail_d      = tail_q;
        case (cap_state_q)
            CAP_IDLE: begin
                if (cap_accept) begin
                    cap_state_d = CAP_FILL;
                    cap_word_d  = '0;
                end
            end
            CAP_FILL: begin
                if (cap_wr) begin
                    cap_word_d = cap_word_q + BLOCK_OFFSET_WIDTH'(1);
                    if (cap_last) begin
                        cap_state_d = CAP_IDLE;
                        tail_d      = tail_q + PTR_W'(1);
                    end
                end
            end
            default: cap_state_d = CAP_IDLE;
        endcase
    end

    // Drain FSM: head valid comes from the register, so a line finishing
    // capture this cycle is only seen next cycle.
    always_comb begin
        dr_state_d = dr_state_q;
        dr_word_d  = dr_word_q;
        head_d     = head_q;
        case (dr_state_q)
            DR_IDLE: begin
                if (head_meta.valid && dn_write_control_done) begin
                    dr_state_d = DR_GO;
                end
            end
            DR_GO: begin
                dr_state_d = DR_STREAM;
                dr_word_d  = '0;
            end
            DR_STREAM: begin
                if (dn_write_user_we) begin
                    dr_word_d = dr_word_q + BLOCK_OFFSET_WIDTH'(1);
                    if (dr_last) begin
                        dr_state_d = DR_IDLE;
                        head_d     = head_q + PTR_W'(1);
                    end
                end
            end
            default: dr_state_d = DR_IDLE;
        endcase
    end

    // Entry metadata and valid count. Capture completion and a pop in the
    // same cycle cancel out in the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            meta_d[i] = meta_q[i];
        end
        if (cap_accept) begin
            meta_d[tail_q].base = up_write_control_base;
        end
        if (cap_last) begin
            meta_d[tail_q].valid = 1'b1;
        end
        if (dr_last) begin
            meta_d[head_q].valid = 1'b0;
        end

        valid_cnt_d = valid_cnt_q;
        if (cap_last && !dr_last) begin
            valid_cnt_d = valid_cnt_q + OCC_W'(1);
        end else if (!cap_last && dr_last) begin
            valid_cnt_d = valid_cnt_q - OCC_W'(1);
        end
    end

    // Read FSM
    always_comb begin
        rd_state_d = rd_state_q;
        rd_base_d  = rd_base_q;
        rd_len_d   = rd_len_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (up_read_control_go && up_conflict) begin
                    rd_state_d = RD_HOLD;
                    rd_base_d  = up_read_control_base;
                    rd_len_d   = up_read_control_length;
                end
            end
            RD_HOLD: begin
                if (rd_fire_held) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_state_q <= CAP_IDLE;
            cap_word_q  <= '0;
            tail_q      <= '0;
            dr_state_q  <= DR_IDLE;
            dr_word_q   <= '0;
            head_q      <= '0;
            rd_state_q  <= RD_IDLE;
            rd_base_q   <= '0;
            rd_len_q    <= '0;
            valid_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            cap_state_q <= cap_state_d;
            cap_word_q  <= cap_word_d;
            tail_q      <= tail_d;
            dr_state_q  <= dr_state_d;
            dr_word_q   <= dr_word_d;
            head_q      <= head_d;
            rd_state_q  <= rd_state_d;
            rd_base_q   <= rd_base_d;
            rd_len_q    <= rd_len_d;
            valid_cnt_q <= valid_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                meta_q[i] <= meta_d[i];
            end
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - directed self-checking bench for writeback_buffer
module tb_writeback_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_write_control_go;
    logic [31:0] up_write_control_base;
    logic [31:0] up_write_control_length;
    logic        up_write_control_done;
    logic [31:0] up_write_user_data;
    logic        up_write_user_we;
    logic        up_write_user_full;
    logic        dn_write_control_go;
    logic [31:0] dn_write_control_base;
    logic [31:0] dn_write_control_length;
    logic        dn_write_control_done;
    logic [31:0] dn_write_user_data;
    logic        dn_write_user_we;
    logic        dn_write_user_full;
    logic        up_read_control_go;
    logic [31:0] up_read_control_base;
    logic [31:0] up_read_control_length;
    logic        up_read_control_done;
    logic        up_read_user_available;
    logic [31:0] up_read_user_data;
    logic        up_read_user_re;
    logic        dn_read_control_go;
    logic [31:0] dn_read_control_base;
    logic [31:0] dn_read_control_length;
    logic        dn_read_control_done;
    logic        dn_read_user_available;
    logic [31:0] dn_read_user_data;
    logic        dn_read_user_re;
    logic [1:0]  occupancy;

    writeback_buffer #(.DEPTH(2), .BLOCK_OFFSET_WIDTH(2)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .up_write_control_go     (up_write_control_go),
        .up_write_control_base   (up_write_control_base),
        .up_write_control_length (up_write_control_length),
        .up_write_control_done   (up_write_control_done),
        .up_write_user_data      (up_write_user_data),
        .up_write_user_we        (up_write_user_we),
        .up_write_user_full      (up_write_user_full),
        .dn_write_control_go     (dn_write_control_go),
        .dn_write_control_base   (dn_write_control_base),
        .dn_write_control_length (dn_write_control_length),
        .dn_write_control_done   (dn_write_control_done),
        .dn_write_user_data      (dn_write_user_data),
        .dn_write_user_we        (dn_write_user_we),
        .dn_write_user_full      (dn_write_user_full),
        .up_read_control_go      (up_read_control_go),
        .up_read_control_base    (up_read_control_base),
        .up_read_control_length  (up_read_control_length),
        .up_read_control_done    (up_read_control_done),
        .up_read_user_available  (up_read_user_available),
        .up_read_user_data       (up_read_user_data),
        .up_read_user_re         (up_read_user_re),
        .dn_read_control_go      (dn_read_control_go),
        .dn_read_control_base    (dn_read_control_base),
        .dn_read_control_length  (dn_read_control_length),
        .dn_read_control_done    (dn_read_control_done),
        .dn_read_user_available  (dn_read_user_available),
        .dn_read_user_data       (dn_read_user_data),
        .dn_read_user_re         (dn_read_user_re),
        .occupancy               (occupancy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int last_cap_cyc = 0;
    int we_viol = 0;

    logic [31:0] wgo_base_q[$];
    logic [31:0] wgo_len_q[$];
    int          wgo_cyc_q[$];
    logic [31:0] word_q[$];
    int          word_cyc_q[$];
    logic [31:0] rgo_base_q[$];
    logic [31:0] rgo_len_q[$];
    int          rgo_cyc_q[$];

    // Downstream memory observer
    always @(negedge clk) begin
        if (!rst) begin
            if (dn_write_control_go) begin
                wgo_base_q.push_back(dn_write_control_base);
                wgo_len_q.push_back(dn_write_control_length);
                wgo_cyc_q.push_back(cyc);
            end
            if (dn_write_user_we) begin
                word_q.push_back(dn_write_user_data);
                word_cyc_q.push_back(cyc);
            end
            if (dn_write_user_we && dn_write_user_full) we_viol++;
            if (dn_read_control_go) begin
                rgo_base_q.push_back(dn_read_control_base);
                rgo_len_q.push_back(dn_read_control_length);
                rgo_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        wgo_base_q.delete(); wgo_len_q.delete(); wgo_cyc_q.delete();
        word_q.delete(); word_cyc_q.delete();
        rgo_base_q.delete(); rgo_len_q.delete(); rgo_cyc_q.delete();
        we_viol = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush(input logic [31:0] b, input logic [31:0] d0);
        int n;
        n = 0;
        @(negedge clk);
        while (!up_write_control_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (up_write_control_done !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait_done base=%h got=%b want=1", b, up_write_control_done);
        end
        @(posedge clk); #1;
        up_write_control_go   = 1'b1;
        up_write_control_base = b;
        @(posedge clk); #1;
        up_write_control_go = 1'b0;
        for (int w = 0; w < 4; w++) begin
            up_write_user_we   = 1'b1;
            up_write_user_data = d0 + 32'(w);
            last_cap_cyc       = cyc;
            @(posedge clk); #1;
        end
        up_write_user_we = 1'b0;
    endtask

    task automatic wait_dn_go();
        int n;
        n = 0;
        @(negedge clk);
        while (!dn_write_control_go && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dn_write_control_go !== 1'b1) begin
            errors++;
            $display("FAIL wait_dn_go got=%b want=1", dn_write_control_go);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(2);
        @(negedge clk);
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        checks++; if (up_write_control_done !== 1'b1) begin errors++; $display("FAIL reset_up_done got=%b want=1", up_write_control_done); end
        checks++; if (dn_write_control_go !== 1'b0) begin errors++; $display("FAIL reset_dn_wgo got=%b want=0", dn_write_control_go); end
        checks++; if (dn_write_user_we !== 1'b0) begin errors++; $display("FAIL reset_dn_we got=%b want=0", dn_write_user_we); end
        checks++; if (dn_read_control_go !== 1'b0) begin errors++; $display("FAIL reset_dn_rgo got=%b want=0", dn_read_control_go); end
        checks++; if (up_write_user_full !== 1'b0) begin errors++; $display("FAIL reset_user_full got=%b want=0", up_write_user_full); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        @(posedge clk); #1;
        dn_read_user_available = 1'b1;
        dn_read_user_data      = 32'h1234_5678;
        up_read_user_re        = 1'b1;
        @(negedge clk);
        checks++; if (up_read_user_data !== 32'h1234_5678) begin errors++; $display("FAIL pass_data got=%h want=12345678", up_read_user_data); end
        checks++; if (up_read_user_available !== 1'b1) begin errors++; $display("FAIL pass_avail got=%b want=1", up_read_user_available); end
        checks++; if (dn_read_user_re !== 1'b1) begin errors++; $display("FAIL pass_re got=%b want=1", dn_read_user_re); end
        @(posedge clk); #1;
        dn_read_user_available = 1'b0;
        up_read_user_re        = 1'b0;
    endtask

    task automatic test_single_flush();
        clear_logs();
        flush(32'h0001040, 32'hA0);
        @(negedge clk);
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL single_occ_after_cap got=%0d want=1", occupancy); end
        wait_cycles(10);
        checks++; if (wgo_base_q.size() !== 1) begin errors++; $display("FAIL single_go_count got=%0d want=1", wgo_base_q.size()); end
        else begin
            checks++; if (wgo_base_q[0] !== 32'h0001040) begin errors++; $display("FAIL single_go_base got=%h want=00001040", wgo_base_q[0]); end
            checks++; if (wgo_len_q[0] !== 32'd16) begin errors++; $display("FAIL single_go_len got=%0d want=16", wgo_len_q[0]); end
            checks++; if (wgo_cyc_q[0] !== last_cap_cyc + 2) begin errors++; $display("FAIL single_go_latency got=%0d want=%0d", wgo_cyc_q[0], last_cap_cyc + 2); end
        end
        checks++; if (word_q.size() !== 4) begin errors++; $display("FAIL single_word_count got=%0d want=4", word_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (word_q[i] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL single_word%0d got=%h want=%h", i, word_q[i], 32'hA0 + 32'(i)); end
            end
            checks++; if (word_cyc_q[3] - word_cyc_q[0] !== 3) begin errors++; $display("FAIL single_throughput got=%0d want=3", word_cyc_q[3] - word_cyc_q[0]); end
        end
        @(negedge clk);
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL single_occ_final got=%0d want=0", occupancy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_words[8];
        clear_logs();
        dn_write_control_done = 1'b0;
        flush(32'h0002000, 32'hB0);
        flush(32'h0003000, 32'hC0);
        @(negedge clk);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL b2b_occ_full got=%0d want=2", occupancy); end
        checks++; if (up_write_control_done !== 1'b0) begin errors++; $display("FAIL b2b_done_full got=%b want=0", up_write_control_done); end
        @(posedge clk); #1;
        up_write_control_go   = 1'b1;
        up_write_control_base = 32'h0009000;
        @(posedge clk); #1;
        up_write_control_go = 1'b0;
        wait_cycles(3);
        @(negedge clk);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL b2b_third_ignored got=%0d want=2", occupancy); end
        checks++; if (wgo_base_q.size() !== 0) begin errors++; $display("FAIL b2b_no_drain got=%0d want=0", wgo_base_q.size()); end
        @(posedge clk); #1;
        dn_write_control_done = 1'b1;
        wait_cycles(25);
        checks++; if (wgo_base_q.size() !== 2) begin errors++; $display("FAIL b2b_go_count got=%0d want=2", wgo_base_q.size()); end
        else begin
            checks++; if (wgo_base_q[0] !== 32'h0002000) begin errors++; $display("FAIL b2b_go0 got=%h want=00002000", wgo_base_q[0]); end
            checks++; if (wgo_base_q[1] !== 32'h0003000) begin errors++; $display("FAIL b2b_go1 got=%h want=00003000", wgo_base_q[1]); end
        end
        for (int i = 0; i < 4; i++) begin
            exp_words[i]     = 32'hB0 + 32'(i);
            exp_words[i + 4] = 32'hC0 + 32'(i);
        end
        checks++; if (word_q.size() !== 8) begin errors++; $display("FAIL b2b_word_count got=%0d want=8", word_q.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (word_q[i] !== exp_words[i]) begin errors++; $display("FAIL b2b_word%0d got=%h want=%h", i, word_q[i], exp_words[i]); end
            end
        end
        @(negedge clk);
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL b2b_occ_final got=%0d want=0", occupancy); end
    endtask

    task automatic test_read_conflict();
        clear_logs();
        dn_write_user_full = 1'b1;
        flush(32'h0001040, 32'hD0);
        wait_cycles(3);
        @(posedge clk); #1;
        up_read_control_go     = 1'b1;
        up_read_control_base   = 32'h0001040;
        up_read_control_length = 32'd16;
        @(negedge clk);
        checks++; if (dn_read_control_go !== 1'b0) begin errors++; $display("FAIL conf_go_withheld got=%b want=0", dn_read_control_go); end
        @(posedge clk); #1;
        up_read_control_go   = 1'b0;
        up_read_control_base = 32'h0;
        wait_cycles(4);
        @(negedge clk);
        checks++; if (rgo_base_q.size() !== 0) begin errors++; $display("FAIL conf_still_held got=%0d want=0", rgo_base_q.size()); end
        checks++; if (up_read_control_done !== 1'b0) begin errors++; $display("FAIL conf_up_done_hold got=%b want=0", up_read_control_done); end
        @(posedge clk); #1;
        dn_write_user_full = 1'b0;
        wait_cycles(10);
        checks++; if (rgo_base_q.size() !== 1) begin errors++; $display("FAIL conf_release_count got=%0d want=1", rgo_base_q.size()); end
        else begin
            checks++; if (rgo_base_q[0] !== 32'h0001040) begin errors++; $display("FAIL conf_release_base got=%h want=00001040", rgo_base_q[0]); end
            checks++; if (rgo_len_q[0] !== 32'd16) begin errors++; $display("FAIL conf_release_len got=%0d want=16", rgo_len_q[0]); end
            if (word_cyc_q.size() == 4) begin
                checks++; if (rgo_cyc_q[0] !== word_cyc_q[3] + 1) begin errors++; $display("FAIL conf_release_cycle got=%0d want=%0d", rgo_cyc_q[0], word_cyc_q[3] + 1); end
            end else begin
                checks++; errors++; $display("FAIL conf_word_count got=%0d want=4", word_cyc_q.size());
            end
        end
        // Empty buffer: refill passes straight through in the same cycle.
        @(posedge clk); #1;
        up_read_control_go     = 1'b1;
        up_read_control_base   = 32'h0002000;
        up_read_control_length = 32'd16;
        @(negedge clk);
        checks++; if (dn_read_control_go !== 1'b1) begin errors++; $display("FAIL nonconf_go got=%b want=1", dn_read_control_go); end
        checks++; if (dn_read_control_base !== 32'h0002000) begin errors++; $display("FAIL nonconf_base got=%h want=00002000", dn_read_control_base); end
        @(posedge clk); #1;
        up_read_control_go = 1'b0;
    endtask

    task automatic test_unrelated_read();
        clear_logs();
        dn_write_user_full = 1'b1;
        flush(32'h0001040, 32'hE0);
        wait_cycles(2);
        @(posedge clk); #1;
        up_read_control_go     = 1'b1;
        up_read_control_base   = 32'h0002000;
        up_read_control_length = 32'd16;
        @(negedge clk);
`ifdef WRITEBACK_BUFFER_HAZARD_CHECK_EN
        checks++; if (dn_read_control_go !== 1'b1) begin errors++; $display("FAIL unrel_pass got=%b want=1", dn_read_control_go); end
        @(posedge clk); #1;
        up_read_control_go = 1'b0;
        dn_write_user_full = 1'b0;
        wait_cycles(10);
`else
        checks++; if (dn_read_control_go !== 1'b0) begin errors++; $display("FAIL unrel_held got=%b want=0", dn_read_control_go); end
        @(posedge clk); #1;
        up_read_control_go = 1'b0;
        wait_cycles(3);
        dn_write_user_full = 1'b0;
        wait_cycles(10);
        checks++; if (rgo_base_q.size() !== 1) begin errors++; $display("FAIL unrel_release_count got=%0d want=1", rgo_base_q.size()); end
        else begin
            checks++; if (rgo_base_q[0] !== 32'h0002000) begin errors++; $display("FAIL unrel_release_base got=%h want=00002000", rgo_base_q[0]); end
            if (word_cyc_q.size() == 4) begin
                checks++; if (rgo_cyc_q[0] !== word_cyc_q[3] + 1) begin errors++; $display("FAIL unrel_release_cycle got=%0d want=%0d", rgo_cyc_q[0], word_cyc_q[3] + 1); end
            end
        end
`endif
        @(negedge clk);
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL unrel_occ_final got=%0d want=0", occupancy); end
    endtask

    task automatic test_full_toggle();
        logic [31:0] exp_words[8];
        clear_logs();
        fork
            begin
                flush(32'h0005000, 32'h50);
                flush(32'h0006000, 32'h60);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk); #1;
                    dn_write_user_full = i[0];
                end
            end
        join
        dn_write_user_full = 1'b0;
        wait_cycles(15);
        for (int i = 0; i < 4; i++) begin
            exp_words[i]     = 32'h50 + 32'(i);
            exp_words[i + 4] = 32'h60 + 32'(i);
        end
        checks++; if (we_viol !== 0) begin errors++; $display("FAIL toggle_we_while_full got=%0d want=0", we_viol); end
        checks++; if (wgo_base_q.size() !== 2) begin errors++; $display("FAIL toggle_go_count got=%0d want=2", wgo_base_q.size()); end
        checks++; if (word_q.size() !== 8) begin errors++; $display("FAIL toggle_word_count got=%0d want=8", word_q.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (word_q[i] !== exp_words[i]) begin errors++; $display("FAIL toggle_word%0d got=%h want=%h", i, word_q[i], exp_words[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        dn_write_user_full = 1'b1;
        flush(32'h0004000, 32'h10);
        wait_dn_go();
        @(posedge clk); #1;
        dn_write_user_full = 1'b0;
        @(negedge clk);
        checks++; if (dn_write_user_we !== 1'b1) begin errors++; $display("FAIL rstmid_streaming got=%b want=1", dn_write_user_we); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        @(negedge clk);
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rstmid_occ got=%0d want=0", occupancy); end
        checks++; if (dn_write_user_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got=%b want=0", dn_write_user_we); end
        checks++; if (dn_write_control_go !== 1'b0) begin errors++; $display("FAIL rstmid_wgo got=%b want=0", dn_write_control_go); end
        checks++; if (up_write_control_done !== 1'b1) begin errors++; $display("FAIL rstmid_up_done got=%b want=1", up_write_control_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cycles(10);
        checks++; if (word_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_words got=%0d want=0", word_q.size()); end
        checks++; if (wgo_base_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_go got=%0d want=0", wgo_base_q.size()); end
    endtask

    initial begin
        rst                     = 1'b1;
        up_write_control_go     = 1'b0;
        up_write_control_base   = '0;
        up_write_control_length = 32'd16;
        up_write_user_data      = '0;
        up_write_user_we        = 1'b0;
        dn_write_control_done   = 1'b1;
        dn_write_user_full      = 1'b0;
        up_read_control_go      = 1'b0;
        up_read_control_base    = '0;
        up_read_control_length  = '0;
        up_read_user_re         = 1'b0;
        dn_read_control_done    = 1'b1;
        dn_read_user_available  = 1'b0;
        dn_read_user_data       = '0;

        test_reset();
        test_passthrough();
        test_single_flush();
        test_back_to_back();
        test_read_conflict();
        test_unrelated_read();
        test_full_toggle();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
